// File: rtl/d8_hazard_unit.sv
// Hazard unit for the dumb8 pipeline: tracks DEPTH in-flight destinations, decides
// issue vs. bubble, produces forwarding selects and a saturating stall counter.

module d8_hazard_cmp #(
  parameter int RW = 8
) (
  input  logic          v,
  input  logic [RW-1:0] dst,
  input  logic [RW-1:0] src_b,
  input  logic [RW-1:0] src_c,
  input  logic          rd_b,
  input  logic          rd_c,
  output logic          mb,
  output logic          mc
);
  assign mb = v & rd_b & (dst == src_b);
  assign mc = v & rd_c & (dst == src_c);
endmodule

module d8_hazard_unit #(
  parameter int DEPTH   = 2,
  parameter int FORWARD = 0,
  parameter int RW      = 8,
  parameter int SW      = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          li_di_valid,
  input  logic [7:0]    li_di_op,
  input  logic [RW-1:0] li_di_a,
  input  logic [RW-1:0] li_di_b,
  input  logic [RW-1:0] li_di_c,
  input  logic          flush,
  output logic          en,
  output logic [7:0]    li_di_op_out,
  output logic [SW-1:0] fwd_b,
  output logic [SW-1:0] fwd_c,
  output logic [15:0]   stall_count
);
  localparam logic [7:0] OP_ADD = 8'h01, OP_SOU = 8'h02, OP_SHL = 8'h03, OP_SHR = 8'h04;
  localparam logic [7:0] OP_COP = 8'h05, OP_AFC = 8'h06, OP_LOD = 8'h07, OP_STR = 8'h08;
  localparam logic [7:0] OP_JMP = 8'h09, OP_JMZ = 8'h0A, OP_VWR = 8'h0B;

  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][RW-1:0] dst_pipe;
  logic                     ld0;  // only the youngest entry's load flag is ever consulted
  logic                     rd_b, rd_c, wr;
  logic [DEPTH-1:0]         mb, mc;
  logic                     hazard, issue;

  always_comb begin
    rd_b = 1'b0;
    rd_c = 1'b0;
    wr   = 1'b0;
    case (li_di_op)
      OP_ADD, OP_SOU, OP_SHL, OP_SHR: begin rd_b = 1'b1; rd_c = 1'b1; wr = 1'b1; end
      OP_VWR:                         begin rd_b = 1'b1; rd_c = 1'b1; end
      OP_COP:                         begin rd_b = 1'b1; wr = 1'b1; end
      OP_STR, OP_JMZ, OP_JMP:         rd_b = 1'b1;
      OP_AFC, OP_LOD:                 wr = 1'b1;
      default: ;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    d8_hazard_cmp #(.RW(RW)) u_cmp (
      .v     (vld_pipe[k]),
      .dst   (dst_pipe[k]),
      .src_b (li_di_b),
      .src_c (li_di_c),
      .rd_b  (rd_b),
      .rd_c  (rd_c),
      .mb    (mb[k]),
      .mc    (mc[k])
    );
  end

  always_comb begin
    if (FORWARD != 0) hazard = (mb[0] | mc[0]) & ld0;
    else              hazard = |{mb, mc};
  end

  assign issue        = li_di_valid & ~hazard & ~flush;
  assign en           = ~(li_di_valid & hazard & ~flush);
  assign li_di_op_out = issue ? li_di_op : 8'h00;

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_b = '0;
    fwd_c = '0;
    if (FORWARD != 0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (mb[k]) fwd_b = SW'(k + 1);
        if (mc[k]) fwd_c = SW'(k + 1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe    <= '0;
      dst_pipe    <= '0;
      ld0         <= 1'b0;
      stall_count <= '0;
    end else begin
      vld_pipe[0] <= issue & wr;
      dst_pipe[0] <= li_di_a;
      ld0         <= (li_di_op == OP_LOD);
      // A flush also kills the entry that was youngest this cycle.
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] & ~(flush && k == 1);
        dst_pipe[k] <= dst_pipe[k-1];
      end
      if (!en && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_d8_hazard_unit.sv
// Bench for d8_hazard_unit: three configurations share one random/directed stream and are
// checked against a timestamped write-list model.

module tb_d8_hazard_unit;
  localparam logic [7:0] NOP = 8'h00, ADD = 8'h01, SOU = 8'h02, SHL = 8'h03, SHR = 8'h04;
  localparam logic [7:0] COP = 8'h05, AFC = 8'h06, LOD = 8'h07, STR = 8'h08, JMP = 8'h09;
  localparam logic [7:0] JMZ = 8'h0A, VWR = 8'h0B, MUL = 8'h0C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic valid = 1'b0, flush = 1'b0;
  logic [7:0] op = 8'h00, a = 8'h00, b = 8'h00, c = 8'h00;
  logic [2:0]       en;
  logic [2:0][7:0]  oo;
  logic [2:0][3:0]  fb, fc;
  logic [2:0][15:0] sc;

  d8_hazard_unit #(.DEPTH(2), .FORWARD(0), .RW(8), .SW(4)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .li_di_valid(valid), .li_di_op(op), .li_di_a(a),
    .li_di_b(b), .li_di_c(c), .flush(flush), .en(en[0]), .li_di_op_out(oo[0]),
    .fwd_b(fb[0]), .fwd_c(fc[0]), .stall_count(sc[0]));
  d8_hazard_unit #(.DEPTH(2), .FORWARD(1), .RW(8), .SW(4)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .li_di_valid(valid), .li_di_op(op), .li_di_a(a),
    .li_di_b(b), .li_di_c(c), .flush(flush), .en(en[1]), .li_di_op_out(oo[1]),
    .fwd_b(fb[1]), .fwd_c(fc[1]), .stall_count(sc[1]));
  d8_hazard_unit #(.DEPTH(8), .FORWARD(0), .RW(8), .SW(4)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .li_di_valid(valid), .li_di_op(op), .li_di_a(a),
    .li_di_b(b), .li_di_c(c), .flush(flush), .en(en[2]), .li_di_op_out(oo[2]),
    .fwd_b(fb[2]), .fwd_c(fc[2]), .stall_count(sc[2]));

  // Model: every issued write is remembered with the cycle it issued in.
  typedef struct { int inst; int cyc; logic [7:0] dst; bit ld; } wr_t;
  wr_t wq[$];
  int  now = 0;
  int  depth[3] = '{2, 2, 8};
  bit  fmode[3] = '{0, 1, 0};
  int  m_sc[3]  = '{0, 0, 0};
  bit  m_en[3], m_iss[3];
  int  total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit reads_b(input logic [7:0] o);
    return o inside {ADD, SOU, SHL, SHR, VWR, COP, STR, JMZ, JMP};
  endfunction
  function automatic bit reads_c(input logic [7:0] o);
    return o inside {ADD, SOU, SHL, SHR, VWR};
  endfunction
  function automatic bit writes(input logic [7:0] o);
    return o inside {ADD, SOU, SHL, SHR, COP, AFC, LOD};
  endfunction

  task automatic model(input int i, output bit me, output int mo, output int mfb, output int mfc,
                       output bit miss);
    int ab = -1, ac = -1;
    bit haz = 0;
    foreach (wq[j]) begin
      int age;
      bit hb, hc;
      if (wq[j].inst != i) continue;
      age = now - wq[j].cyc - 1;
      if (age < 0 || age >= depth[i]) continue;
      hb = reads_b(op) && wq[j].dst == b;
      hc = reads_c(op) && wq[j].dst == c;
      if (hb && (ab < 0 || age < ab)) ab = age;
      if (hc && (ac < 0 || age < ac)) ac = age;
      if ((hb || hc) && (!fmode[i] || (age == 0 && wq[j].ld))) haz = 1;
    end
    miss = valid && !flush && !haz;
    me   = !(valid && !flush && haz);
    mo   = miss ? int'(op) : 0;
    mfb  = (fmode[i] && ab >= 0) ? ab + 1 : 0;
    mfc  = (fmode[i] && ac >= 0) ? ac + 1 : 0;
  endtask

  task automatic step(input bit v, input logic [7:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] cc, input bit f);
    @(negedge clk);
    valid = v; op = o; a = aa; b = bb; c = cc; flush = f;
    #1;
    for (int i = 0; i < 3; i++) begin
      bit me, mi;
      int mo, mfb, mfc;
      model(i, me, mo, mfb, mfc, mi);
      m_en[i] = me; m_iss[i] = mi;
      chk($sformatf("en%0d", i),  32'(en[i]), 32'(me));
      chk($sformatf("op%0d", i),  32'(oo[i]), 32'(mo));
      chk($sformatf("fb%0d", i),  32'(fb[i]), 32'(mfb));
      chk($sformatf("fc%0d", i),  32'(fc[i]), 32'(mfc));
      chk($sformatf("sc%0d", i),  32'(sc[i]), 32'(m_sc[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (m_iss[i] && writes(o)) begin
        wr_t w;
        w.inst = i; w.cyc = now; w.dst = aa; w.ld = (o == LOD);
        wq.push_back(w);
      end
      if (f)
        for (int j = wq.size() - 1; j >= 0; j--)
          if (wq[j].inst == i && wq[j].cyc == now - 1) wq.delete(j);
      if (!m_en[i] && m_sc[i] < 65535) m_sc[i]++;
    end
    now++;
    for (int j = wq.size() - 1; j >= 0; j--)
      if (now - wq[j].cyc - 1 >= 8) wq.delete(j);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, NOP, 0, 0, 0, 0);
  endtask

  logic [7:0] ops[13] = '{NOP, ADD, SOU, SHL, SHR, COP, AFC, LOD, STR, JMP, JMZ, VWR, MUL};

  initial begin
    // Reset state: empty tracker, valid instruction passes straight through.
    valid = 1; op = ADD; a = 8'd4; b = 8'd3; c = 8'd5;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_en", 32'(en[i]), 32'd1);
      chk("rst_op", 32'(oo[i]), 32'(ADD));
      chk("rst_sc", 32'(sc[i]), 32'd0);
      chk("rst_fb", 32'(fb[i]), 32'd0);
    end
    @(negedge clk); rst_n = 1;

    // AFC r3 then ADD r4,r3,r5 on DEPTH=2 stall mode: two bubbles then issue.
    step(1, AFC, 3, 0, 0, 0);
    step(1, ADD, 4, 3, 5, 0); chk("raw_en1", 32'(en[0]), 0); chk("raw_op1", 32'(oo[0]), 0);
    step(1, ADD, 4, 3, 5, 0); chk("raw_en2", 32'(en[0]), 0);
    step(1, ADD, 4, 3, 5, 0); chk("raw_en3", 32'(en[0]), 1); chk("raw_op3", 32'(oo[0]), 32'(ADD));
    chk("raw_sc", 32'(sc[0]), 2);
    idle(9);

    // Forwarding: distance 1 and distance 2.
    step(1, ADD, 3, 1, 2, 0);
    step(1, SOU, 6, 5, 3, 0);
    chk("fwd1_en", 32'(en[1]), 1); chk("fwd1_c", 32'(fc[1]), 1); chk("fwd1_b", 32'(fb[1]), 0);
    idle(9);
    step(1, ADD, 3, 1, 2, 0);
    step(1, NOP, 0, 0, 0, 0);
    step(1, SOU, 6, 5, 3, 0); chk("fwd2_c", 32'(fc[1]), 2);
    idle(9);

    // Load-use: one bubble then forward from stage 1.
    step(1, LOD, 7, 0, 0, 0);
    step(1, COP, 8, 7, 0, 0); chk("lu_en0", 32'(en[1]), 0); chk("lu_op0", 32'(oo[1]), 0);
    step(1, COP, 8, 7, 0, 0); chk("lu_en1", 32'(en[1]), 1); chk("lu_fb", 32'(fb[1]), 2);
    idle(9);

    // Flush over a pending hazard kills the producer too.
    step(1, AFC, 3, 0, 0, 0);
    step(1, ADD, 4, 3, 5, 1); chk("fl_en", 32'(en[0]), 1); chk("fl_op", 32'(oo[0]), 0);
    step(1, ADD, 4, 3, 5, 0); chk("fl_next", 32'(en[0]), 1);
    idle(9);

    // Random mix over a small register set to provoke many dependencies.
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 9) != 0), ops[$urandom_range(0, 12)], 8'($urandom_range(0, 3)),
           8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));

    // Self-dependent stream keeps the DEPTH=8 unit stalling 8 of every 9 cycles.
    for (int n = 0; n < 74000; n++) step(1, ADD, 1, 1, 1, 0);
    chk("sat", 32'(sc[2]), 32'hFFFF);
    step(1, ADD, 1, 1, 1, 0);
    step(1, ADD, 1, 1, 1, 0);
    chk("sat_hold", 32'(sc[2]), 32'hFFFF);
    idle(9);

    // Asynchronous reset in the middle of a stall.
    step(1, AFC, 3, 0, 0, 0);
    @(negedge clk);
    valid = 1; op = ADD; a = 4; b = 3; c = 5; flush = 0;
    #1 chk("pre_rst_en", 32'(en[0]), 0);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_en", 32'(en[i]), 1);
      chk("arst_sc", 32'(sc[i]), 0);
      chk("arst_fb", 32'(fb[i]), 0);
      chk("arst_fc", 32'(fc[i]), 0);
    end
    wq.delete();
    m_sc = '{0, 0, 0};
    @(negedge clk); rst_n = 1;
    step(1, ADD, 4, 3, 5, 0); chk("post_rst_en", 32'(en[0]), 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/d8_hazard_unit.md
# d8_hazard_unit

Parametrised hazard unit for the dumb8 pipeline. It replaces the fixed two-stage hazard check with a DEPTH-entry in-flight destination tracker and an optional forwarding mode. It sits between the LI/DI decode latch and the DI/EX stage. Each cycle it either issues the decoded instruction, or freezes the front-end and injects a NOP bubble (opcode 0x00). It also produces operand-forwarding selects and a saturating stall counter.

## Interface
- DEPTH, 2: number of tracked in-flight stages between issue and register write-back (1..8).
- FORWARD, 0: 0 = stall on any RAW hazard; 1 = forward from tracked stages and stall only on load-use.
- RW, 8: register index width (matches the a/b/c instruction fields).
- SW, 3: forward-select width; must satisfy 2^SW > DEPTH.

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- li_di_valid  in  1  a decoded instruction is present.
- li_di_op  in  8  opcode (d8.vh encoding).
- li_di_a / li_di_b / li_di_c  in  RW each  destination, source 1, source 2.
- flush  in  1  taken branch; kills the instruction presented this cycle and the youngest tracked entry.
- en  out  1  1 = front-end advances; 0 = front-end holds its registers.
- li_di_op_out  out  8  opcode to DI/EX; 0x00 when a bubble is inserted.
- fwd_b / fwd_c  out  SW each  0 = register file; k+1 = value from tracked stage k.
- stall_count  out  16  number of cycles with en=0; saturates at 0xFFFF.

## Operation
- Classes:
  - Writers: ADD SOU SHL SHR COP AFC LOD.
  - Readers of b and c: ADD SOU SHL SHR VWR.
  - Readers of b only: COP STR JMZ JMP.
  - All other opcodes read and write nothing.
- Tracker: entries trk[0..DEPTH-1], each holding {v, dst[RW], ld}. trk[0] is the youngest.
  - Every cycle: trk[k+1] <= trk[k], and trk[DEPTH-1] retires.
  - trk[0] loads {1, li_di_a, op==LOD} when an instruction issues and its op is a writer.
  - Otherwise trk[0] loads v=0.
- Match: match_b[k] = trk[k].v & (trk[k].dst == li_di_b) & (op reads b). match_c is defined the same way for c.
- Hazard when FORWARD=0: any match_b or match_c asserted, at any k.
- Hazard when FORWARD=1: match in trk[0] with trk[0].ld=1 (load-use) only.
- Issue condition: li_di_valid & ~hazard & ~flush.
  - On issue: en=1 and li_di_op_out=li_di_op.
  - On hazard: en=0 and li_di_op_out=0x00. The instruction is held and re-evaluated next cycle.
  - On flush: en=1, li_di_op_out=0x00, and trk[0] is loaded invalid. Flush takes priority over hazard.
  - li_di_valid=0 with no flush: en=1, li_di_op_out=0x00.
- Forward select (FORWARD=1 only; otherwise 0): fwd_b = k+1 for the smallest k with match_b[k], 0 if none. fwd_c is derived the same way. The youngest producer wins.
- stall_count increments on every cycle with en=0 and holds at 0xFFFF.

## Timing
- Reset (sys_rst_n=0, asynchronous): all trk[k].v=0 and stall_count=0.
  - Combinational outputs then follow the rules with an empty tracker: en=1, fwd_b=fwd_c=0, li_di_op_out=li_di_op when valid, 0x00 when not valid.
- en, li_di_op_out, fwd_b and fwd_c are combinational from the inputs and tracker state in the same cycle.
- Tracker and stall_count update one edge later.
- Stall length when FORWARD=0: a reader issued right after a writer to the same register stalls DEPTH cycles. In general it stalls DEPTH-k cycles for a producer in trk[k].
- Stall length when FORWARD=1: load-use stalls exactly 1 cycle; other dependencies stall 0 cycles.
- A writer and a same-cycle reader of the same register within one instruction (e.g. ADD r1,r1,r2) is not a hazard. Only tracked entries are compared.
- Reset released mid-stall: the tracker is empty, so the held instruction issues in the first cycle after release.
- Register index 0 has no special meaning; it is tracked like any other index.

## Test plan
- FORWARD=0, DEPTH=2: AFC r3 then ADD r4,r3,r5 back-to-back -> en=0 and op_out=0x00 for 2 cycles, then ADD issues. stall_count=2.
- FORWARD=1, DEPTH=2: ADD r3 then SOU r6,r5,r3 -> no stall, fwd_c=1 and fwd_b=0. Insert one NOP between them instead -> fwd_c=2.
- FORWARD=1: LOD r7 then COP r8,r7 -> 1 bubble, then COP issues with fwd_b=2.
- FORWARD=0 hazard pending, flush asserted -> en=1, op_out=0x00, trk[0].v=0. Next cycle a reader of the killed destination (previously trk[0]) does not stall.
- Drive a permanent hazard: hold trk via a continuous LOD stream with FORWARD=1 and a forced stall for 70000 cycles -> stall_count saturates at 0xFFFF.
- Assert sys_rst_n=0 asynchronously during a stall -> en=1 immediately, stall_count=0, fwd_b=fwd_c=0.
